fmadd_lzd_merge_stage: RTL

FMADD_LZD_MERGE_STAGE -- requirements
Module: fmadd_lzd_merge_stage

---
 rtl/fmadd_lzd_merge_stage.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fmadd_lzd_merge_stage.sv
// Two-stage leading-zero detector for the FMA normaliser: pair flags are merged into
// three 8-bit groups in stage 1, then into a 24-bit count and a normalising shift in stage 2.
module fmadd_lzd_merge_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_pos_val,
  input  logic [23:0] in_man,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_lzc,
  output logic        out_zero,
  output logic [23:0] out_norm_man
);

  // Handshake: a beat moves on a side when valid & ready are both high at the rising edge.
  // in_ready depends only on pipeline occupancy and out_ready, never on in_valid.
  // flush empties both stages at the next edge and overrides every transfer.

  typedef struct packed {
    logic       val;
    logic [2:0] cnt;
  } grp8_t;

  // pv = {val_u, pos_u, val_l, pos_l}; result = {val, cnt[1:0]}
  function automatic logic [2:0] merge_quad(input logic [3:0] pv);
    logic [2:0] r;
    r[2]   = pv[3] | pv[1];
    r[1:0] = pv[3] ? {1'b0, pv[2]} : {1'b1, pv[0]};
    return r;
  endfunction

  function automatic grp8_t merge_oct(input logic [7:0] pv);
    logic [2:0] q_u;
    logic [2:0] q_l;
    grp8_t      g;
    q_u   = merge_quad(pv[7:4]);
    q_l   = merge_quad(pv[3:0]);
    g.val = q_u[2] | q_l[2];
    g.cnt = q_u[2] ? {1'b0, q_u[1:0]} : {1'b1, q_l[1:0]};
    return g;
  endfunction

  logic        adv1;
  logic        adv2;
  logic        s1_valid;
  grp8_t       s1_g2;
  grp8_t       s1_g1;
  grp8_t       s1_g0;
  logic [23:0] s1_man;

  grp8_t       g2_d;
  grp8_t       g1_d;
  grp8_t       g0_d;

  logic        val16;
  logic [3:0]  cnt16;
  logic        zero_d;
  logic [4:0]  lzc_d;
  logic [23:0] norm_d;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  // Group 2 holds pairs 11..8 (mantissa bits 23:16) and has top priority.
  assign g2_d = merge_oct(in_pos_val[23:16]);
  assign g1_d = merge_oct(in_pos_val[15:8]);
  assign g0_d = merge_oct(in_pos_val[7:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_g2    <= '0;
      s1_g1    <= '0;
      s1_g0    <= '0;
      s1_man   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_g2  <= g2_d;
        s1_g1  <= g1_d;
        s1_g0  <= g0_d;
        s1_man <= in_man;
      end
    end
  end

  always_comb begin
    val16  = s1_g2.val | s1_g1.val;
    cnt16  = s1_g2.val ? {1'b0, s1_g2.cnt} : {1'b1, s1_g1.cnt};
    zero_d = !(val16 | s1_g0.val);
    lzc_d  = 5'd24;
    norm_d = '0;
    if (val16) begin
      lzc_d = {1'b0, cnt16};
    end else if (s1_g0.val) begin
      lzc_d = 5'd16 + {2'b00, s1_g0.cnt};
    end
    if (!zero_d) begin
      norm_d = s1_man << lzc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_lzc      <= '0;
      out_zero     <= 1'b0;
      out_norm_man <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_lzc      <= lzc_d;
        out_zero     <= zero_d;
        out_norm_man <= norm_d;
      end
    end
  end

endmodule
